branch_resolution_queue: RTL and testbench

Tracks every conditional branch the branch predictor steers fetch past, and checks each prediction against the outcome from execute. Branches retire in program order. For each retiring branch the block reports the branch's PC and instruction word back to the predictor. On a misprediction it drives a one-cycle flush pulse plus the corrected fetch address, which is the same flush, retire_pc and retire_instruction the predictor uses to repair its BTB entry. It sits between fetch (enqueue side), execute (resolve side) and the predictor/frontend (retire/flush side).

---
 rtl/branch_resolution_queue_if.sv | 37 +++
 rtl/branch_resolution_queue.sv | 97 +++++++++
 tb/tb_branch_resolution_queue.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/branch_resolution_queue_if.sv
// branch_resolution_queue_if: fetch/execute/retire bundle for the branch resolution queue.
interface branch_resolution_queue_if #(
    parameter int DEPTH            = 8,
    parameter int ADDRESS_SIZE     = 64,
    parameter int INSTRUCTION_SIZE = 32,
    parameter int TAG_W            = $clog2(DEPTH)
);
    logic                        enq_valid;
    logic                        enq_ready;
    logic [ADDRESS_SIZE-1:0]     enq_pc;
    logic [INSTRUCTION_SIZE-1:0] enq_instruction;
    logic                        enq_pred_taken;
    logic [ADDRESS_SIZE-1:0]     enq_pred_target;
    logic [TAG_W-1:0]            enq_tag;
    logic                        resolve_valid;
    logic [TAG_W-1:0]            resolve_tag;
    logic                        resolve_taken;
    logic [ADDRESS_SIZE-1:0]     resolve_target;
    logic                        retire_valid;
    logic [ADDRESS_SIZE-1:0]     retire_pc;
    logic [INSTRUCTION_SIZE-1:0] retire_instruction;
    logic                        flush;
    logic [ADDRESS_SIZE-1:0]     redirect_pc;
    logic                        frontend_stall;
    modport master (
        output enq_valid, enq_pc, enq_instruction, enq_pred_taken, enq_pred_target,
        output resolve_valid, resolve_tag, resolve_taken, resolve_target,
        input  enq_ready, enq_tag, retire_valid, retire_pc, retire_instruction,
        input  flush, redirect_pc, frontend_stall
    );
    modport slave (
        input  enq_valid, enq_pc, enq_instruction, enq_pred_taken, enq_pred_target,
        input  resolve_valid, resolve_tag, resolve_taken, resolve_target,
        output enq_ready, enq_tag, retire_valid, retire_pc, retire_instruction,
        output flush, redirect_pc, frontend_stall
    );
endinterface

// File: rtl/branch_resolution_queue.sv
// branch_resolution_queue: in-order tracker of predicted branches; retires them and flushes on mispredict.
module branch_resolution_queue #(
    parameter int DEPTH            = 8,
    parameter int ADDRESS_SIZE     = 64,
    parameter int INSTRUCTION_SIZE = 32,
    parameter int TAG_W            = $clog2(DEPTH)
) (
    input logic                      clk,
    input logic                      reset,
    branch_resolution_queue_if.slave bus
);
    localparam int CW = TAG_W + 1;
    typedef enum logic {RUN, FLUSH} state_e;
    state_e                      state_q;
    logic [DEPTH-1:0]            valid_q, resolved_q, pred_taken_q, act_taken_q;
    logic [ADDRESS_SIZE-1:0]     pc_q [DEPTH];
    logic [ADDRESS_SIZE-1:0]     pred_target_q [DEPTH];
    logic [ADDRESS_SIZE-1:0]     act_target_q [DEPTH];
    logic [INSTRUCTION_SIZE-1:0] instr_q [DEPTH];
    logic [TAG_W-1:0]            head_q, tail_q;
    logic [CW-1:0]               count_q, count_d;
    logic                        retire_valid_q, flush_q;
    logic [ADDRESS_SIZE-1:0]     retire_pc_q, redirect_q;
    logic [INSTRUCTION_SIZE-1:0] retire_instr_q;
    logic                        enq_ready, enq_fire, res_fire, head_done, mispredict;
    always_comb begin
        enq_ready  = (state_q == RUN) && (count_q != CW'(DEPTH)) && !reset;
        enq_fire   = bus.enq_valid && enq_ready;
        res_fire   = bus.resolve_valid && valid_q[bus.resolve_tag] && !resolved_q[bus.resolve_tag];
        head_done  = (state_q == RUN) && valid_q[head_q] && resolved_q[head_q];
        mispredict = (pred_taken_q[head_q] != act_taken_q[head_q]) ||
                     (act_taken_q[head_q] && (pred_target_q[head_q] != act_target_q[head_q]));
        count_d    = count_q + CW'(enq_fire) - CW'(head_done && !mispredict);
    end
    // A mispredicted head is not popped: the following FLUSH cycle wipes the whole queue.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= RUN;
            valid_q        <= '0;
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            retire_valid_q <= 1'b0;
            flush_q        <= 1'b0;
            retire_pc_q    <= '0;
            retire_instr_q <= '0;
            redirect_q     <= '0;
        end else begin
            retire_valid_q <= 1'b0;
            flush_q        <= 1'b0;
            if (state_q == FLUSH) begin
                valid_q <= '0;
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
                state_q <= RUN;
            end else begin
                if (res_fire) begin
                    resolved_q[bus.resolve_tag]   <= 1'b1;
                    act_taken_q[bus.resolve_tag]  <= bus.resolve_taken;
                    act_target_q[bus.resolve_tag] <= bus.resolve_target;
                end
                if (enq_fire) begin
                    valid_q[tail_q]       <= 1'b1;
                    resolved_q[tail_q]    <= 1'b0;
                    pc_q[tail_q]          <= bus.enq_pc;
                    instr_q[tail_q]       <= bus.enq_instruction;
                    pred_taken_q[tail_q]  <= bus.enq_pred_taken;
                    pred_target_q[tail_q] <= bus.enq_pred_target;
                    tail_q                <= tail_q + TAG_W'(1);
                end
                if (head_done) begin
                    retire_valid_q <= 1'b1;
                    retire_pc_q    <= pc_q[head_q];
                    retire_instr_q <= instr_q[head_q];
                    flush_q        <= mispredict;
                    if (mispredict) begin
                        redirect_q <= act_taken_q[head_q] ? act_target_q[head_q] : pc_q[head_q] + ADDRESS_SIZE'(4);
                        state_q    <= FLUSH;
                    end else begin
                        valid_q[head_q] <= 1'b0;
                        head_q          <= head_q + TAG_W'(1);
                    end
                end
                count_q <= count_d;
            end
        end
    end
    assign bus.enq_ready          = enq_ready;
    assign bus.frontend_stall     = !enq_ready;
    assign bus.enq_tag            = tail_q;
    assign bus.retire_valid       = retire_valid_q;
    assign bus.retire_pc          = retire_pc_q;
    assign bus.retire_instruction = retire_instr_q;
    assign bus.flush              = flush_q;
    assign bus.redirect_pc        = redirect_q;
endmodule

// File: tb/tb_branch_resolution_queue.sv
// tb_branch_resolution_queue: random stimulus against an in-order branch list model with a retire scoreboard.
module tb_branch_resolution_queue;
    localparam int DEPTH = 8;
    localparam int AW    = 64;
    localparam int IW    = 32;
    localparam int TW    = $clog2(DEPTH);
    typedef struct {
        logic [TW-1:0] tag;
        logic [AW-1:0] pc;
        logic [IW-1:0] ins;
        logic          pt;
        logic [AW-1:0] ptg;
        logic          res;
        logic          at;
        logic [AW-1:0] atg;
    } br_t;
    typedef struct {
        int            cyc;
        logic [AW-1:0] pc;
        logic [IW-1:0] ins;
        logic          fl;
        logic [AW-1:0] rd;
    } exp_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    branch_resolution_queue_if #(.DEPTH(DEPTH), .ADDRESS_SIZE(AW), .INSTRUCTION_SIZE(IW), .TAG_W(TW)) bus ();
    branch_resolution_queue #(.DEPTH(DEPTH), .ADDRESS_SIZE(AW), .INSTRUCTION_SIZE(IW), .TAG_W(TW)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    br_t  infl[$];
    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   next_tag = 0;
    bit   flushing = 1'b0;
    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h cyc %0d", nm, act, exp, cyc);
        end
    endtask
    function automatic bit model_ready();
        return !reset && !flushing && infl.size() < DEPTH;
    endfunction
    // Reference: a program-ordered list of in-flight branches; the oldest retires once resolved.
    task automatic model_step();
        br_t hd;
        bit  h, mis, rdy;
        if (reset) begin
            infl.delete();
            expq.delete();
            flushing = 1'b0;
            next_tag = 0;
            return;
        end
        if (flushing) begin
            infl.delete();
            next_tag = 0;
            flushing = 1'b0;
            return;
        end
        rdy = model_ready();
        h = infl.size() > 0 && infl[0].res;
        if (h) hd = infl[0];
        if (bus.resolve_valid)
            foreach (infl[i])
                if (infl[i].tag == bus.resolve_tag && !infl[i].res) begin
                    infl[i].res = 1'b1;
                    infl[i].at  = bus.resolve_taken;
                    infl[i].atg = bus.resolve_target;
                end
        if (bus.enq_valid && rdy) begin
            infl.push_back('{TW'(next_tag), bus.enq_pc, bus.enq_instruction, bus.enq_pred_taken,
                             bus.enq_pred_target, 1'b0, 1'b0, '0});
            next_tag = (next_tag + 1) % DEPTH;
        end
        if (h) begin
            mis = (hd.pt != hd.at) || (hd.at && hd.ptg != hd.atg);
            expq.push_back('{cyc, hd.pc, hd.ins, mis, hd.at ? hd.atg : hd.pc + 64'd4});
            if (mis) flushing = 1'b1;
            else void'(infl.pop_front());
        end
    endtask
    task automatic tick();
        @(posedge clk);
        cyc++;
        model_step();
        @(negedge clk);
        chk("enq_ready", 64'(bus.enq_ready), 64'(model_ready()));
        chk("frontend_stall", 64'(bus.frontend_stall), 64'(!model_ready()));
        if (model_ready()) chk("enq_tag", 64'(bus.enq_tag), 64'(next_tag));
    endtask
    task automatic idle();
        bus.enq_valid       = 1'b0;
        bus.enq_pc          = '0;
        bus.enq_instruction = '0;
        bus.enq_pred_taken  = 1'b0;
        bus.enq_pred_target = '0;
        bus.resolve_valid   = 1'b0;
        bus.resolve_tag     = '0;
        bus.resolve_taken   = 1'b0;
        bus.resolve_target  = '0;
    endtask
    task automatic drive(int enq_pct, int res_pct, int mis_pct, bit rev);
        int  idx[$];
        int  k;
        br_t e;
        bus.enq_valid       = $urandom_range(99) < enq_pct;
        bus.enq_pc          = ($urandom_range(15) == 0) ? 64'hFFFF_FFFF_FFFF_FFFC : {$urandom, $urandom} & ~64'h3;
        bus.enq_instruction = $urandom;
        bus.enq_pred_taken  = 1'($urandom_range(1));
        bus.enq_pred_target = {$urandom, $urandom} & ~64'h3;
        bus.resolve_valid   = 1'b0;
        bus.resolve_tag     = TW'($urandom_range(DEPTH - 1));
        bus.resolve_taken   = 1'($urandom_range(1));
        bus.resolve_target  = {$urandom, $urandom};
        if ($urandom_range(99) < res_pct) begin
            bus.resolve_valid = 1'b1;
            foreach (infl[i]) if (!infl[i].res) idx.push_back(i);
            if (idx.size() > 0 && $urandom_range(9) != 0) begin
                k = rev ? idx[idx.size() - 1] : idx[$urandom_range(idx.size() - 1)];
                e = infl[k];
                bus.resolve_tag = e.tag;
                if ($urandom_range(99) < mis_pct) begin
                    if (!e.pt || $urandom_range(1) == 0) bus.resolve_taken = !e.pt;
                    else begin
                        bus.resolve_taken  = 1'b1;
                        bus.resolve_target = e.ptg + 64'h40;
                    end
                end else begin
                    bus.resolve_taken = e.pt;
                    if (e.pt) bus.resolve_target = e.ptg;
                end
            end
        end
    endtask
    task automatic chk_zero();
        chk("rst_retire_valid", 64'(bus.retire_valid), 64'd0);
        chk("rst_flush", 64'(bus.flush), 64'd0);
        chk("rst_retire_pc", bus.retire_pc, 64'd0);
        chk("rst_retire_instruction", 64'(bus.retire_instruction), 64'd0);
        chk("rst_redirect_pc", bus.redirect_pc, 64'd0);
    endtask
    always @(negedge clk) begin
        exp_t e;
        if (bus.retire_valid || bus.flush) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_retire got pc %h flush %b exp none cyc %0d", bus.retire_pc, bus.flush, cyc);
            end else begin
                e = expq.pop_front();
                chk("retire_cycle", 64'(cyc), 64'(e.cyc));
                chk("retire_valid", 64'(bus.retire_valid), 64'd1);
                chk("retire_pc", bus.retire_pc, e.pc);
                chk("retire_instruction", 64'(bus.retire_instruction), 64'(e.ins));
                chk("flush", 64'(bus.flush), 64'(e.fl));
                if (e.fl) chk("redirect_pc", bus.redirect_pc, e.rd);
            end
        end else if (expq.size() > 0 && expq[0].cyc <= cyc) begin
            e = expq.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_retire got none exp pc %h cyc %0d", e.pc, cyc);
        end
    end
    initial begin
        idle();
        reset = 1'b1;
        @(negedge clk);
        repeat (3) tick();
        chk_zero();
        reset = 1'b0;
        repeat (12) begin drive(100, 0, 0, 1'b0); tick(); end
        repeat (25) begin drive(0, 100, 0, 1'b1); tick(); end
        repeat (1500) begin drive(60, 40, 15, 1'b0); tick(); end
        repeat (3) begin drive(100, 0, 0, 1'b0); tick(); end
        idle();
        reset = 1'b1;
        repeat (2) tick();
        chk_zero();
        reset = 1'b0;
        repeat (20) begin drive(0, 100, 0, 1'b0); tick(); end
        repeat (1000) begin drive(80, 30, 5, 1'b0); tick(); end
        for (int i = 0; i < 300 && (infl.size() > 0 || flushing); i++) begin
            drive(0, 100, 0, 1'b0);
            tick();
        end
        if (infl.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout got %0d pending exp 0", infl.size());
        end
        idle();
        repeat (4) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
